// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the master bridge state encoding.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_master_state_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Request/ack port to APB4 initiator bridge. One outstanding transfer,
// one-entry request latch, and an ACCESS-phase timeout so a hung slave
// cannot lock up the requester.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter logic [2:0] PPROT          = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [APB_STRB_W-1:0] inport_wr_i,
    input  logic                  inport_rd_i,
    input  logic [7:0]            inport_len_i,
    input  logic [APB_ADDR_W-1:0] inport_addr_i,
    input  logic [APB_DATA_W-1:0] inport_write_data_i,
    output logic                  inport_accept_o,
    output logic                  inport_ack_o,
    output logic                  inport_error_o,
    output logic [APB_DATA_W-1:0] inport_read_data_o,

    output logic [APB_ADDR_W-1:0] out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [APB_DATA_W-1:0] out_pwdata,
    output logic [APB_STRB_W-1:0] out_pstrb,
    input  logic                  out_pready,
    input  logic [APB_DATA_W-1:0] out_prdata,
    input  logic                  out_pslverr
);

    // A zero timeout disables the abort path; keep the counter at least one bit wide.
    localparam int               CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int               CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_LAST_I[CNT_W-1:0];
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    apb_master_state_t     r_state;
    logic [APB_ADDR_W-1:0] r_paddr;
    logic [APB_DATA_W-1:0] r_pwdata;
    logic [APB_STRB_W-1:0] r_pstrb;
    logic                  r_pwrite;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_ack;
    logic                  r_error;
    logic [APB_DATA_W-1:0] r_read_data;
    logic [CNT_W-1:0]      r_cnt;

    logic w_is_write;
    logic w_req;
    logic w_illegal;
    logic w_timeout_hit;

    // Request decode: simultaneous read+write or any burst length is rejected.
    always_comb begin
        w_is_write    = |inport_wr_i;
        w_req         = w_is_write || inport_rd_i;
        w_illegal     = (w_is_write && inport_rd_i) || (inport_len_i != 8'd0);
        w_timeout_hit = TIMEOUT_EN && (r_cnt == CNT_LAST);
    end

    // Single FSM with the request latch, APB controls and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_ack       <= 1'b0;
            r_error     <= 1'b0;
            r_read_data <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            // Rejected without touching the bus; answer on the next cycle.
                            r_ack       <= 1'b1;
                            r_error     <= 1'b1;
                            r_read_data <= '0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_paddr  <= inport_addr_i;
                            r_pwdata <= inport_write_data_i;
                            r_pstrb  <= inport_wr_i;
                            r_pwrite <= w_is_write;
                            r_psel   <= 1'b1;
                            r_state  <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over a timeout expiring on the same cycle.
                    if (out_pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_ack       <= 1'b1;
                        r_error     <= out_pslverr;
                        r_read_data <= r_pwrite ? '0 : out_prdata;
                        r_state     <= ST_RESP;
                    end else if (w_timeout_hit) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_ack       <= 1'b1;
                        r_error     <= 1'b1;
                        r_read_data <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_ack     <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive: accept is a pure function of state, everything else is registered.
    always_comb begin
        inport_accept_o    = (r_state == ST_IDLE);
        inport_ack_o       = r_ack;
        inport_error_o     = r_error;
        inport_read_data_o = r_read_data;
        out_paddr          = r_paddr;
        out_psel           = r_psel;
        out_penable        = r_penable;
        out_pprot          = PPROT;
        out_pwrite         = r_pwrite;
        out_pwdata         = r_pwdata;
        out_pstrb          = r_pstrb;
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge built with an 8-cycle timeout.
module tb_apb_master_bridge;

    logic        clock;
    logic        reset;
    logic [3:0]  inport_wr_i;
    logic        inport_rd_i;
    logic [7:0]  inport_len_i;
    logic [31:0] inport_addr_i;
    logic [31:0] inport_write_data_i;
    logic        inport_accept_o;
    logic        inport_ack_o;
    logic        inport_error_o;
    logic [31:0] inport_read_data_o;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int errors = 0;
    int checks = 0;

    apb_master_bridge #(
        .PPROT          (3'b000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .inport_wr_i         (inport_wr_i),
        .inport_rd_i         (inport_rd_i),
        .inport_len_i        (inport_len_i),
        .inport_addr_i       (inport_addr_i),
        .inport_write_data_i (inport_write_data_i),
        .inport_accept_o     (inport_accept_o),
        .inport_ack_o        (inport_ack_o),
        .inport_error_o      (inport_error_o),
        .inport_read_data_o  (inport_read_data_o),
        .out_paddr           (out_paddr),
        .out_psel            (out_psel),
        .out_penable         (out_penable),
        .out_pprot           (out_pprot),
        .out_pwrite          (out_pwrite),
        .out_pwdata          (out_pwdata),
        .out_pstrb           (out_pstrb),
        .out_pready          (out_pready),
        .out_prdata          (out_prdata),
        .out_pslverr         (out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and land 2 time units after the edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] wr, input logic rd, input logic [7:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
        inport_wr_i         = wr;
        inport_rd_i         = rd;
        inport_len_i        = len;
        inport_addr_i       = addr;
        inport_write_data_i = wdata;
    endtask

    task automatic idle_req();
        req(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
    endtask

    initial begin
        reset       = 1'b1;
        out_pready  = 1'b1;
        out_prdata  = 32'h0;
        out_pslverr = 1'b0;
        idle_req();

        // ---- Reset state
        tick();
        tick();
        chk("rst_accept", {31'd0, inport_accept_o}, 32'd1);
        chk("rst_psel", {31'd0, out_psel}, 32'd0);
        chk("rst_penable", {31'd0, out_penable}, 32'd0);
        chk("rst_ack", {31'd0, inport_ack_o}, 32'd0);
        chk("rst_error", {31'd0, inport_error_o}, 32'd0);
        chk("rst_rdata", inport_read_data_o, 32'd0);
        chk("rst_paddr", out_paddr, 32'd0);
        chk("rst_pprot", {29'd0, out_pprot}, 32'd0);
        reset = 1'b0;
        tick();

        // ---- Write, slave ready immediately
        req(4'b0011, 1'b0, 8'd0, 32'h8000_0010, 32'hDEAD_BEEF);
        #1;
        chk("wr_accept", {31'd0, inport_accept_o}, 32'd1);
        tick();
        idle_req();
        chk("wr_setup_psel", {31'd0, out_psel}, 32'd1);
        chk("wr_setup_pen", {31'd0, out_penable}, 32'd0);
        chk("wr_setup_accept", {31'd0, inport_accept_o}, 32'd0);
        chk("wr_paddr", out_paddr, 32'h8000_0010);
        chk("wr_pwdata", out_pwdata, 32'hDEAD_BEEF);
        chk("wr_pstrb", {28'd0, out_pstrb}, 32'h3);
        chk("wr_pwrite", {31'd0, out_pwrite}, 32'd1);
        tick();
        chk("wr_access_psel", {31'd0, out_psel}, 32'd1);
        chk("wr_access_pen", {31'd0, out_penable}, 32'd1);
        chk("wr_access_ack", {31'd0, inport_ack_o}, 32'd0);
        tick();
        chk("wr_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("wr_error", {31'd0, inport_error_o}, 32'd0);
        chk("wr_resp_psel", {31'd0, out_psel}, 32'd0);
        tick();
        chk("wr_ack_pulse", {31'd0, inport_ack_o}, 32'd0);
        chk("wr_idle_accept", {31'd0, inport_accept_o}, 32'd1);

        // ---- Read with 5 wait states
        out_pready = 1'b0;
        req(4'h0, 1'b1, 8'd0, 32'h1000_0004, 32'h5555_AAAA);
        tick();
        idle_req();
        chk("rd_pstrb", {28'd0, out_pstrb}, 32'd0);
        chk("rd_pwrite", {31'd0, out_pwrite}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_wait_psel", {31'd0, out_psel}, 32'd1);
            chk("rd_wait_pen", {31'd0, out_penable}, 32'd1);
            chk("rd_wait_paddr", out_paddr, 32'h1000_0004);
            chk("rd_wait_ack", {31'd0, inport_ack_o}, 32'd0);
        end
        tick();
        chk("rd_last_pen", {31'd0, out_penable}, 32'd1);
        out_pready = 1'b1;
        out_prdata = 32'h1234_5678;
        tick();
        out_prdata = 32'h0;
        chk("rd_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("rd_data", inport_read_data_o, 32'h1234_5678);
        chk("rd_error", {31'd0, inport_error_o}, 32'd0);
        tick();
        chk("rd_hold_data", inport_read_data_o, 32'h1234_5678);

        // ---- Read with slave error, then an immediate follow-on read
        req(4'h0, 1'b1, 8'd0, 32'h2000_0000, 32'h0);
        tick();
        idle_req();
        tick();
        out_pslverr = 1'b1;
        out_prdata  = 32'hCAFE_0001;
        tick();
        out_pslverr = 1'b0;
        chk("slverr_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("slverr_error", {31'd0, inport_error_o}, 32'd1);
        tick();
        chk("slverr_next_accept", {31'd0, inport_accept_o}, 32'd1);
        out_prdata = 32'h0BAD_F00D;
        req(4'h0, 1'b1, 8'd0, 32'h2000_0008, 32'h0);
        tick();
        idle_req();
        chk("next_rd_psel", {31'd0, out_psel}, 32'd1);
        tick();
        tick();
        chk("next_rd_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("next_rd_data", inport_read_data_o, 32'h0BAD_F00D);
        chk("next_rd_error", {31'd0, inport_error_o}, 32'd0);
        tick();

        // ---- Timeout: pready stuck low for 8 ACCESS cycles
        out_pready = 1'b0;
        out_prdata = 32'hFFFF_FFFF;
        req(4'h0, 1'b1, 8'd0, 32'h3000_0000, 32'h0);
        tick();
        idle_req();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_access_psel", {31'd0, out_psel}, 32'd1);
        end
        tick();
        chk("to_psel_drop", {31'd0, out_psel}, 32'd0);
        chk("to_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("to_error", {31'd0, inport_error_o}, 32'd1);
        chk("to_rdata", inport_read_data_o, 32'd0);
        tick();

        // ---- pready arrives on the 8th ACCESS cycle: normal completion
        out_prdata = 32'h8888_0008;
        req(4'h0, 1'b1, 8'd0, 32'h3000_0004, 32'h0);
        tick();
        idle_req();
        for (int i = 0; i < 7; i++) tick();
        tick();
        out_pready = 1'b1;
        chk("late_psel", {31'd0, out_psel}, 32'd1);
        tick();
        chk("late_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("late_error", {31'd0, inport_error_o}, 32'd0);
        chk("late_rdata", inport_read_data_o, 32'h8888_0008);
        tick();

        // ---- Illegal: read and write together
        req(4'hF, 1'b1, 8'd0, 32'h4000_0000, 32'h1111_2222);
        #1;
        chk("ill_rw_accept", {31'd0, inport_accept_o}, 32'd1);
        tick();
        idle_req();
        chk("ill_rw_psel", {31'd0, out_psel}, 32'd0);
        chk("ill_rw_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("ill_rw_error", {31'd0, inport_error_o}, 32'd1);
        chk("ill_rw_rdata", inport_read_data_o, 32'd0);
        tick();
        chk("ill_rw_ack_pulse", {31'd0, inport_ack_o}, 32'd0);

        // ---- Illegal: nonzero burst length
        req(4'h0, 1'b1, 8'd3, 32'h4000_0004, 32'h0);
        tick();
        idle_req();
        chk("ill_len_psel", {31'd0, out_psel}, 32'd0);
        chk("ill_len_ack", {31'd0, inport_ack_o}, 32'd1);
        chk("ill_len_error", {31'd0, inport_error_o}, 32'd1);
        tick();

        // ---- Reset during ACCESS
        out_pready = 1'b0;
        req(4'h0, 1'b1, 8'd0, 32'h5000_0000, 32'h0);
        tick();
        idle_req();
        tick();
        tick();
        chk("mid_pre_pen", {31'd0, out_penable}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_psel", {31'd0, out_psel}, 32'd0);
        chk("mid_rst_pen", {31'd0, out_penable}, 32'd0);
        chk("mid_rst_accept", {31'd0, inport_accept_o}, 32'd1);
        chk("mid_rst_ack", {31'd0, inport_ack_o}, 32'd0);
        out_pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_ack", {31'd0, inport_ack_o}, 32'd0);
            chk("mid_no_psel", {31'd0, out_psel}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the SDRAM-controller-style request port (inport_*: byte-strobe write, read, accept, ack) into APB4 initiator transactions on an out_* APB bus.
- Counterpart of the APB-to-SDRAM responder bridge; lets a core-side request/ack port drive any APB peripheral, and serves as the bench driver for APB responders.
- Single outstanding transfer, one-entry request latch, bus-hang timeout.

Parameters:
- PPROT, 3'b000, constant value driven on out_pprot.
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- inport_wr_i  in  4  byte write strobes; nonzero = write request
- inport_rd_i  in  1  read request
- inport_len_i  in  8  burst length; only 0 supported
- inport_addr_i  in  32  byte address
- inport_write_data_i  in  32  write data
- inport_accept_o  out  1  request taken this cycle
- inport_ack_o  out  1  one-cycle completion pulse
- inport_error_o  out  1  valid with ack; slave error, timeout or illegal request
- inport_read_data_o  out  32  read data, valid with ack
- out_paddr  out  32  APB address
- out_psel  out  1  APB select
- out_penable  out  1  APB enable
- out_pprot  out  3  equals PPROT
- out_pwrite  out  1  APB direction
- out_pwdata  out  32  APB write data
- out_pstrb  out  4  APB strobes; 0 for reads
- out_pready  in  1  APB ready
- out_prdata  in  32  APB read data
- out_pslverr  in  1  APB slave error

Behaviour:
- Interface decision: one clock `clock`; reset `reset` is synchronous and active-high.
- States: ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP.
- inport_accept_o = (state==ST_IDLE), combinational. A request is (wr_i!=0)||rd_i. It is taken when accept is high.
- ST_IDLE, legal request taken:
  - Latch addr, wdata, strobes and pwrite=(wr_i!=0).
  - Go to ST_SETUP.
- ST_IDLE, illegal request taken (wr_i!=0 and rd_i both set, or len_i!=0):
  - No APB cycle.
  - Go to ST_RESP with error=1 and read_data=0.
- ST_SETUP:
  - psel=1, penable=0; paddr, pwrite, pwdata and pstrb come from the latch.
  - Unconditionally go to ST_ACCESS.
- ST_ACCESS:
  - psel=1, penable=1, all other APB outputs held stable.
  - When pready=1: capture prdata (reads; 0 for writes) and pslverr, then go to ST_RESP.
  - Timeout counter: cleared on entry, +1 each cycle with pready=0. When it equals TIMEOUT_CYCLES-1 with pready still 0, abort: go to ST_RESP with error=1 and read_data=0. pready on that same cycle wins over the timeout.
  - Counter width: $clog2(TIMEOUT_CYCLES+1). No wrap, because it is cleared on entry.
- ST_RESP:
  - inport_ack_o=1 for exactly one cycle; error and read_data valid.
  - Go to ST_IDLE.
  - Next request is acceptable the cycle after ack.
  - Minimum latency: accept at cycle 0, SETUP 1, ACCESS 2 (pready=1), ack at 3.
- Outside ST_SETUP/ST_ACCESS: psel=0, penable=0.
- out_pstrb = 0 for reads, per APB4. out_paddr is unaligned-passthrough, no masking.
- inport_read_data_o and inport_error_o hold their last value until the next ack.
- Reset, including mid-transfer:
  - Next edge: state=ST_IDLE, psel=0, penable=0, ack=0, error=0, read_data=0, paddr/pwdata/pstrb/pwrite=0, counter=0.
  - An aborted transfer is never acked.
- Request inputs are ignored while accept=0; the requester must hold them until accepted.

Decomposition:
- Shared package apb_pkg:
  - apb_master_state_t enum (ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP).
  - APB_DATA_W=32, APB_ADDR_W=32, APB_STRB_W=4.
- No sub-module. The timeout counter is inline; a single FSM plus datapath registers fits in about 200 lines.

Test Plan:
- Write wr_i=4'b0011, addr=0x8000_0010, data=0xDEAD_BEEF, slave pready=1 immediately -> SETUP then ACCESS with pstrb=0011, pwrite=1; ack 3 cycles after accept, error=0.
- Read addr=0x1000_0004, slave inserts 5 wait states then prdata=0x1234_5678 -> psel/penable held 5 extra cycles with stable paddr; ack with read_data=0x1234_5678, pstrb=0.
- Read with pslverr=1 on the ready cycle -> ack with error=1; next read accepted the cycle after ack.
- TIMEOUT_CYCLES=8, pready stuck 0 -> psel drops after 8 ACCESS cycles; ack with error=1, read_data=0. pready=1 on the 8th cycle instead -> normal completion, error=0.
- rd_i=1 with wr_i=4'hF, and separately len_i=3 -> no psel activity; ack one cycle after accept with error=1.
- reset asserted during ACCESS -> next edge psel=0, penable=0, accept=1; no ack emitted for the aborted transfer.
